// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store unit in front of a
// word-organised data memory with a one-cycle registered read. Sub-word
// loads are lane-selected and extended; sub-word stores are read-modify-
// write. Misaligned or illegal requests complete with resp_err and never
// strobe the memory.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. The response is a
// single-cycle resp_valid pulse with no backpressure.
module load_store_unit #(
    parameter int XLEN       = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_r_enable,
    output logic            mem_w_enable,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    // The RDW state assumes read data arrives exactly one cycle after RD.
    if (MEM_RD_LAT != 1) begin : g_bad_lat
        $error("load_store_unit supports only MEM_RD_LAT == 1");
    end

    typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

    state_t          state, state_nxt;
    logic            accept;
    logic            req_err;
    logic            store_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] data_q;
    logic            err_q;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] merged;

    assign accept = req_valid & req_ready;

    // Classify the incoming request: illegal funct3 or misaligned address.
    always_comb begin
        req_err = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            req_err = 1'b1;
        if (req_store && req_funct3[2])
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: word stores skip the read; sub-word stores read first.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                                state_nxt = RESP;
                    else if (req_store && req_funct3 == 3'b010) state_nxt = WR;
                    else                                        state_nxt = RD;
                end
            end
            RD:      state_nxt = RDW;
            RDW:     state_nxt = store_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane extraction and extension of the word returned by memory.
    always_comb begin
        lane_b   = '0;
        lane_h   = '0;
        load_val = mem_rdata;
        case (addr_q[1:0])
            2'b00:   lane_b = mem_rdata[7:0];
            2'b01:   lane_b = mem_rdata[15:8];
            2'b10:   lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_val = {{(XLEN-8){lane_b[7]}}, lane_b};
            3'b001:  load_val = {{(XLEN-16){lane_h[15]}}, lane_h};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, lane_b};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, lane_h};
            default: load_val = mem_rdata;
        endcase
    end

    // Merge of sub-word store data into the word read back from memory.
    always_comb begin
        merged = mem_rdata;
        if (f3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merged[7:0]   = data_q[7:0];
                2'b01:   merged[15:8]  = data_q[7:0];
                2'b10:   merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else if (f3_q[1:0] == 2'b01) begin
            if (addr_q[1]) merged[31:16] = data_q[15:0];
            else           merged[15:0]  = data_q[15:0];
        end
    end

    // Request latch at acceptance; data_q later holds the load result or
    // the merged store word.
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            store_q <= req_store;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            data_q  <= req_wdata;
            err_q   <= req_err;
        end else if (state == RDW) begin
            data_q  <= store_q ? merged : load_val;
        end
    end

    // Outputs decoded from state so every strobe is zero in IDLE and RESP.
    always_comb begin
        req_ready    = (state == IDLE);
        mem_r_enable = (state == RD);
        mem_w_enable = (state == WR);
        mem_addr     = '0;
        if (state == RD || state == RDW || state == WR)
            mem_addr = {addr_q[XLEN-1:2], 2'b00};
        mem_wdata    = (state == WR) ? data_q : '0;
        resp_valid   = (state == RESP);
        resp_err     = (state == RESP) && err_q;
        resp_rdata   = (state == RESP && !store_q && !err_q) ? data_q : '0;
    end

endmodule
